ext_int_controller: RTL and testbench

Interrupt controller that collects single-cycle request pulses from several `external_INT_handler` instances and presents one interrupt at a time to the CPU core. It holds a pending bit per source and applies a per-source mask and a global enable. It arbitrates round-robin among enabled pending sources and runs a valid/ack/done handshake with the core's trap logic. It sits between the external interrupt pins' handlers and the core's interrupt entry.

---
 rtl/ext_int_controller.sv | 124 ++++++++++++
 tb/tb_ext_int_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_controller.sv
// External interrupt controller: per-source pending/overrun tracking, mask and global enable,
// round-robin arbitration and a valid/ack/done handshake towards the core.
module ext_int_controller #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] int_req,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic               global_en,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StRequest, StService} state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic [ID_W-1:0]    irq_id_q;
    logic               irq_valid_q;
    logic [ID_W-1:0]    served_id_q;
    logic [ID_W-1:0]    rr_ptr_q;

    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] ack_vec;
    logic               ack_accept;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    probe;

    // (base + off) mod NUM_SRC; operands are always below NUM_SRC, so one subtraction suffices.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W:0]   off);
        logic [ID_W:0] s;
        s = {1'b0, base} + off;
        if (s >= (ID_W+1)'(NUM_SRC)) begin
            s = s - (ID_W+1)'(NUM_SRC);
        end
        return s[ID_W-1:0];
    endfunction

    assign cand       = pending_q & int_mask;
    assign ack_accept = (state_q == StRequest) && irq_ack;
    assign ack_vec    = ack_accept ? (NUM_SRC'(1) << irq_id_q) : '0;

    // A request arriving in the same cycle as the ack wins over the clear.
    assign pending_d = (pending_q & ~ack_vec) | int_req;
    assign overrun_d = (overrun_q & ~ack_vec) | (int_req & pending_q);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        probe  = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            probe = wrap_add(rr_ptr_q, (ID_W+1)'(k));
            if (!found && cand[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            served_id_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (global_en && found) begin
                        irq_id_q    <= winner;
                        irq_valid_q <= 1'b1;
                        state_q     <= StRequest;
                    end
                end
                StRequest: begin
                    // Never withdrawn: mask/global_en changes are ignored until the core acks.
                    if (irq_ack) begin
                        served_id_q <= irq_id_q;
                        irq_valid_q <= 1'b0;
                        state_q     <= StService;
                    end
                end
                StService: begin
                    if (irq_done) begin
                        rr_ptr_q <= wrap_add(served_id_q, (ID_W+1)'(1));
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    irq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ext_int_controller.sv
// Directed bench for ext_int_controller with a per-cycle reference model and literal spot checks.
module tb_ext_int_controller;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  int_req = '0;
    logic [N-1:0]  int_mask = '0;
    logic          global_en = 1'b0;
    logic          irq_valid;
    logic [IW-1:0] irq_id;
    logic          irq_ack = 1'b0;
    logic          irq_done = 1'b0;
    logic [N-1:0]  pending;
    logic [N-1:0]  overrun;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    ext_int_controller #(.NUM_SRC(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_req   (int_req),
        .int_mask  (int_mask),
        .global_en (global_en),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done),
        .pending   (pending),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = presenting, 2 = in service.
    int           m_state, m_id, m_served, m_rr;
    bit           m_valid, m_acc, m_found;
    bit [N-1:0]   m_pend, m_ovr, m_p, m_o;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_id = 0; m_served = 0; m_rr = 0;
            m_valid = 0; m_pend = '0; m_ovr = '0;
        end else begin
            m_p   = m_pend;
            m_o   = m_ovr;
            m_acc = (m_state == 1) && irq_ack;
            if (m_acc) begin
                m_p[m_id] = 1'b0;
                m_o[m_id] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (int_req[i]) begin
                    if (m_pend[i]) m_o[i] = 1'b1;
                    m_p[i] = 1'b1;
                end
            end
            if (m_state == 0) begin
                m_found = 0;
                if (global_en) begin
                    for (int k = 0; k < N; k++) begin
                        if (!m_found && m_pend[(m_rr + k) % N] && int_mask[(m_rr + k) % N]) begin
                            m_found = 1;
                            m_id    = (m_rr + k) % N;
                        end
                    end
                end
                if (m_found) begin
                    m_valid = 1;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (irq_ack) begin
                    m_served = m_id;
                    m_valid  = 0;
                    m_state  = 2;
                end
            end else if (irq_done) begin
                m_rr    = (m_served + 1) % N;
                m_state = 0;
            end
            m_pend = m_p;
            m_ovr  = m_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_valid", 32'(irq_valid), 32'(m_valid));
            if (m_valid) check("model_id", 32'(irq_id), 32'(m_id));
            check("model_pending", 32'(pending), 32'(m_pend));
            check("model_overrun", 32'(overrun), 32'(m_ovr));
            check("model_busy", 32'(busy), 32'(m_state != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] req);
        int_req = req;
        tick();
        int_req = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input int limit);
        int c = 0;
        while (!irq_valid && c < limit) begin
            tick();
            c++;
        end
        check("valid_within_bound", 32'(irq_valid), 32'd1);
    endtask

    task automatic serve(input int exp_id);
        wait_valid(20);
        check("grant_id", 32'(irq_id), 32'(exp_id));
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("acked_busy", 32'(busy), 32'd1);
        check("acked_valid", 32'(irq_valid), 32'd0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int_mask  = 4'b1111;
        global_en = 1'b1;
        do_reset();

        // Reset mid-request acts without a clock edge.
        pulse(4'b0100);
        tick();
        check("pre_reset_id", 32'(irq_id), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_after_reset", 32'(irq_valid), 32'd0);
        end

        // Single source latency and hold.
        pulse(4'b0010);
        check("single_pending", 32'(pending), 32'b0010);
        check("single_not_yet", 32'(irq_valid), 32'd0);
        tick();
        check("single_valid", 32'(irq_valid), 32'd1);
        check("single_id", 32'(irq_id), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("single_hold_id", 32'(irq_id), 32'd1);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("single_cleared", 32'(pending[1]), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("single_done", 32'(busy), 32'd0);

        // Round robin from a fresh pointer.
        do_reset();
        pulse(4'b1011);
        serve(0);
        serve(1);
        serve(3);
        pulse(4'b1111);
        serve(0);
        serve(1);
        serve(2);
        serve(3);

        // Masking.
        int_mask = 4'b0000;
        pulse(4'b0100);
        check("mask_pending", 32'(pending), 32'b0100);
        for (int i = 0; i < 10; i++) tick();
        check("mask_no_valid", 32'(irq_valid), 32'd0);
        int_mask = 4'b0100;
        tick();
        check("unmask_valid", 32'(irq_valid), 32'd1);
        check("unmask_id", 32'(irq_id), 32'd2);
        serve(2);
        int_mask = 4'b1111;
        pulse(4'b0010);
        tick();
        check("hold_valid_pre", 32'(irq_valid), 32'd1);
        int_mask  = 4'b0000;
        global_en = 1'b0;
        tick();
        tick();
        check("hold_valid_unmasked", 32'(irq_valid), 32'd1);
        check("hold_id", 32'(irq_id), 32'd1);
        int_mask  = 4'b1111;
        global_en = 1'b1;
        serve(1);

        // Overrun and set-wins.
        pulse(4'b0001);
        pulse(4'b0001);
        check("overrun_set", 32'(overrun[0]), 32'd1);
        wait_valid(20);
        check("ovr_id", 32'(irq_id), 32'd0);
        irq_ack = 1'b1;
        int_req = 4'b0001;
        tick();
        irq_ack = 1'b0;
        int_req = '0;
        check("setwins_pending", 32'(pending[0]), 32'd1);
        check("setwins_overrun", 32'(overrun[0]), 32'd1);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        serve(0);
        check("overrun_cleared", 32'(overrun[0]), 32'd0);
        check("pending_cleared", 32'(pending), 32'd0);

        // Ignored inputs and no nesting.
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_idle_busy", 32'(busy), 32'd0);
        check("ack_idle_valid", 32'(irq_valid), 32'd0);
        pulse(4'b1000);
        wait_valid(20);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("done_in_req_valid", 32'(irq_valid), 32'd1);
        check("done_in_req_id", 32'(irq_id), 32'd3);
        irq_ack  = 1'b1;
        irq_done = 1'b1;
        tick();
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        check("ack_done_busy", 32'(busy), 32'd1);
        tick();
        check("still_service", 32'(busy), 32'd1);
        pulse(4'b0100);
        tick();
        tick();
        check("no_nest_valid", 32'(irq_valid), 32'd0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        check("gap_busy", 32'(busy), 32'd0);
        check("gap_valid", 32'(irq_valid), 32'd0);
        tick();
        check("after_gap_valid", 32'(irq_valid), 32'd1);
        check("after_gap_id", 32'(irq_id), 32'd2);
        serve(2);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
